mem_access_unit: RTL and testbench

Multi-cycle data-memory access unit sitting between the execute stage and the data memory port. It turns decoded load/store requests into a held request/acknowledge transaction with byte enables. Loads are returned lane-extracted and sign- or zero-extended; stores are lane-aligned. It adds misalignment detection, a wait-state timeout, and pipeline back-pressure.

---
 rtl/mem_access_unit_if.sv | 39 +++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundles the execute-stage request, the data-memory port and the completion
// signals of mem_access_unit. The "slave" modport is the unit's own view.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Request handshake: a request transfers on a cycle where in_valid and
  // in_ready are both high. Upstream keeps every request field stable while
  // in_ready is low. Memory side: mem_en and the request fields hold until
  // the cycle where mem_ack is high.
  logic                in_valid;
  logic                in_ready;
  logic                op_ld;
  logic                op_st;
  logic [1:0]          size;
  logic                sign_ext;
  logic [DATA_W-1:0]   in_a;
  logic [ADDR_W-1:0]   in_b;
  logic                mem_en;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;
  logic                done;
  logic                err;
  logic [DATA_W-1:0]   rd_data;

  modport master (
    output in_valid, op_ld, op_st, size, sign_ext, in_a, in_b, mem_ack, mem_rdata,
    input  in_ready, mem_en, mem_wr, mem_addr, mem_be, mem_wdata, done, err, rd_data
  );

  modport slave (
    input  in_valid, op_ld, op_st, size, sign_ext, in_a, in_b, mem_ack, mem_rdata,
    output in_ready, mem_en, mem_wr, mem_addr, mem_be, mem_wdata, done, err, rd_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns load/store requests into a held en/ack
// memory transaction with byte enables, lane alignment and a wait timeout.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus,
  output logic             dbg_state_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t             state_q;
  logic               mem_en_q;
  logic               mem_wr_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [BE_W-1:0]    mem_be_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               done_q;
  logic               err_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic [OFF_W-1:0]   off_q;
  logic [1:0]         size_q;
  logic               sext_q;
  logic               ld_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [OFF_W-1:0]   off_d;
  logic               illegal_d;
  logic [BE_W-1:0]    be_d;
  logic [DATA_W-1:0]  wmask_d;
  logic [DATA_W-1:0]  wdata_d;
  logic [DATA_W-1:0]  rd_shift;
  logic               rd_sign;
  logic [DATA_W-1:0]  ld_ext_d;
  logic               timeout_hit;

  assign off_d = bus.in_b[OFF_W-1:0];

  // Request decode: legality, byte enables and lane-aligned store data.
  always_comb begin
    illegal_d = bus.op_ld & bus.op_st;
    case (bus.size)
      2'd1:    if (off_d[0]) illegal_d = 1'b1;
      2'd2:    if (off_d[1:0] != 2'b00) illegal_d = 1'b1;
      2'd3:    if (DATA_W == 32 || off_d != '0) illegal_d = 1'b1;
      default: ;
    endcase
    be_d    = '0;
    wmask_d = '0;
    for (int i = 0; i < BE_W; i++) begin
      if (i < (1 << bus.size)) be_d[i] = 1'b1;
    end
    for (int i = 0; i < DATA_W; i++) begin
      if (i < (8 << bus.size)) wmask_d[i] = 1'b1;
    end
    be_d    = be_d << off_d;
    wdata_d = (bus.in_a & wmask_d) << {off_d, 3'b000};
  end

  // Load return path: move the addressed lane to bit 0, then extend.
  always_comb begin
    rd_shift = bus.mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    rd_sign = rd_shift[7];
      2'd1:    rd_sign = rd_shift[15];
      2'd2:    rd_sign = rd_shift[31];
      default: rd_sign = rd_shift[DATA_W-1];
    endcase
    ld_ext_d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < (8 << size_q)) ld_ext_d[i] = rd_shift[i];
      else                   ld_ext_d[i] = sext_q & rd_sign;
    end
  end

  // An ack arriving on the timeout cycle takes priority over the abort.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
      off_q       <= '0;
      size_q      <= 2'd0;
      sext_q      <= 1'b0;
      ld_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid && (bus.op_ld || bus.op_st)) begin
            if (illegal_d) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state_q     <= REQ;
              mem_en_q    <= 1'b1;
              mem_wr_q    <= bus.op_st;
              mem_addr_q  <= bus.in_b;
              mem_be_q    <= be_d;
              mem_wdata_q <= bus.op_st ? wdata_d : '0;
              off_q       <= off_d;
              size_q      <= bus.size;
              sext_q      <= bus.sign_ext;
              ld_q        <= bus.op_ld;
              cnt_q       <= '0;
            end
          end
        end
        REQ: begin
          if (bus.mem_ack || timeout_hit) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b1;
            err_q       <= ~bus.mem_ack;
            if (bus.mem_ack && ld_q) rd_data_q <= ld_ext_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_data   = rd_data_q;
  assign dbg_state_o   = (state_q == REQ);
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit unit with TIMEOUT=4 and a 64-bit unit,
// driven from a vector table, random requests and hand-written sequences.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst32_n;
  logic rst64_n;
  logic dbg32;
  logic dbg64;

  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus32();
  mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) bus64();

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .rst_n(rst32_n), .bus(bus32), .dbg_state_o(dbg32)
  );
  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u_dut64 (
    .clk(clk), .rst_n(rst64_n), .bus(bus64), .dbg_state_o(dbg64)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rdata;
    int          ack_at;    // cycle in which mem_ack is driven; 0 = never
    logic        exp_mem;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [64:0] exp_q[$];   // {err, rd_data}
  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic err, input logic [63:0] rd);
    logic [64:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: done with empty queue, got err=%0b rd=0x%0h required none", name, err, rd);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_err"}, 64'(err), 64'(e[64]));
      chk({name, "_rd"}, rd, e[63:0]);
    end
  endtask

  task automatic sb_drop();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input string tag, input vec_t v);
    int   cyc;
    logic seen;
    int   exp_cyc;
    bus32.in_valid = 1'b1;
    bus32.op_ld    = v.ld;
    bus32.op_st    = v.st;
    bus32.size     = v.size;
    bus32.sign_ext = v.sext;
    bus32.in_a     = v.a;
    bus32.in_b     = v.b;
    chk({tag, "_ready"}, 64'(bus32.in_ready), 64'd1);
    if (v.exp_mem || v.exp_err) exp_q.push_back({v.exp_err, 32'h0, v.exp_rd});
    tick();
    bus32.in_valid = 1'b0;
    bus32.op_ld    = 1'b0;
    bus32.op_st    = 1'b0;
    cyc = 1;
    if (!v.exp_mem) begin
      chk({tag, "_noreq"}, 64'(bus32.mem_en), 64'd0);
      chk({tag, "_done1"}, 64'(bus32.done), 64'(v.exp_err));
      if (bus32.done) sb_pop(tag, bus32.err, 64'(bus32.rd_data));
      else if (v.exp_err) sb_drop();
      chk({tag, "_rdy1"}, 64'(bus32.in_ready), 64'd1);
      tick();
      chk({tag, "_done2"}, 64'(bus32.done), 64'd0);
      return;
    end
    chk({tag, "_en"}, 64'(bus32.mem_en), 64'd1);
    chk({tag, "_wr"}, 64'(bus32.mem_wr), 64'(v.st));
    chk({tag, "_addr"}, 64'(bus32.mem_addr), 64'(v.b));
    chk({tag, "_be"}, 64'(bus32.mem_be), 64'(v.exp_be));
    chk({tag, "_wdata"}, 64'(bus32.mem_wdata), 64'(v.exp_wdata));
    chk({tag, "_busy"}, 64'(bus32.in_ready), 64'd0);
    exp_cyc = (v.ack_at != 0) ? v.ack_at + 1 : 5;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      bus32.mem_ack   = (cyc == v.ack_at);
      bus32.mem_rdata = v.rdata;
      tick();
      bus32.mem_ack = 1'b0;
      cyc++;
      if (bus32.done) begin
        seen = 1'b1;
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
        sb_pop(tag, bus32.err, 64'(bus32.rd_data));
        chk({tag, "_endef"}, 64'(bus32.mem_en), 64'd0);
      end else begin
        chk({tag, "_hold_en"}, 64'(bus32.mem_en), 64'd1);
        chk({tag, "_hold_be"}, 64'(bus32.mem_be), 64'(v.exp_be));
        chk({tag, "_hold_wd"}, 64'(bus32.mem_wdata), 64'(v.exp_wdata));
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_wait: no done after %0d cycles, required done by cycle %0d", tag, cyc, exp_cyc);
      sb_drop();
    end
    tick();
    chk({tag, "_pulse"}, 64'(bus32.done), 64'd0);
  endtask

  function automatic vec_t mk_rand();
    vec_t v;
    int   off;
    logic [31:0] f;
    v.ld     = 1'($urandom_range(0, 1));
    v.st     = ~v.ld;
    v.size   = 2'($urandom_range(0, 2));
    v.sext   = 1'($urandom_range(0, 1));
    v.a      = $urandom;
    v.rdata  = $urandom;
    v.ack_at = $urandom_range(0, 4);
    off = $urandom_range(0, 3);
    if (v.size == 2'd1) off = off & 2;
    if (v.size == 2'd2) off = 0;
    v.b = ($urandom & 32'hFFFF_FFFC) | 32'(off);
    v.exp_mem = 1'b1;
    f = v.rdata >> (8 * off);
    case (v.size)
      2'd0: begin
        v.exp_be    = 4'(4'b0001 << off);
        v.exp_wdata = {24'h0, v.a[7:0]} << (8 * off);
        v.exp_rd    = v.sext ? {{24{f[7]}}, f[7:0]} : {24'h0, f[7:0]};
      end
      2'd1: begin
        v.exp_be    = 4'(4'b0011 << off);
        v.exp_wdata = {16'h0, v.a[15:0]} << (8 * off);
        v.exp_rd    = v.sext ? {{16{f[15]}}, f[15:0]} : {16'h0, f[15:0]};
      end
      default: begin
        v.exp_be    = 4'hF;
        v.exp_wdata = v.a;
        v.exp_rd    = f;
      end
    endcase
    if (v.st) v.exp_rd = 32'h0;
    else      v.exp_wdata = 32'h0;
    v.exp_err = (v.ack_at == 0);
    if (v.exp_err) v.exp_rd = 32'h0;
    return v;
  endfunction

  task automatic run64(input string tag, input logic ld, input logic st, input logic [1:0] size,
                       input logic sext, input logic [63:0] a, input logic [31:0] b,
                       input logic [63:0] rdata, input logic [7:0] exp_be,
                       input logic [63:0] exp_wdata, input logic [63:0] exp_rd);
    bus64.in_valid = 1'b1;
    bus64.op_ld    = ld;
    bus64.op_st    = st;
    bus64.size     = size;
    bus64.sign_ext = sext;
    bus64.in_a     = a;
    bus64.in_b     = b;
    exp_q.push_back({1'b0, exp_rd});
    tick();
    bus64.in_valid = 1'b0;
    chk({tag, "_en"}, 64'(bus64.mem_en), 64'd1);
    chk({tag, "_be"}, 64'(bus64.mem_be), 64'(exp_be));
    chk({tag, "_wdata"}, bus64.mem_wdata, exp_wdata);
    bus64.mem_ack   = 1'b1;
    bus64.mem_rdata = rdata;
    tick();
    bus64.mem_ack = 1'b0;
    chk({tag, "_done"}, 64'(bus64.done), 64'd1);
    if (bus64.done) sb_pop(tag, bus64.err, bus64.rd_data);
    else sb_drop();
    tick();
    chk({tag, "_pulse"}, 64'(bus64.done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst32_n = 1'b0;
    rst64_n = 1'b0;
    bus32.in_valid = 1'b0; bus32.op_ld = 1'b0; bus32.op_st = 1'b0; bus32.size = 2'd0;
    bus32.sign_ext = 1'b0; bus32.in_a = '0; bus32.in_b = '0; bus32.mem_ack = 1'b0; bus32.mem_rdata = '0;
    bus64.in_valid = 1'b0; bus64.op_ld = 1'b0; bus64.op_st = 1'b0; bus64.size = 2'd0;
    bus64.sign_ext = 1'b0; bus64.in_a = '0; bus64.in_b = '0; bus64.mem_ack = 1'b0; bus64.mem_rdata = '0;

    //       ld    st    size  sext  a             b            rdata         ack mem   be     wdata         err   rd
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        32'h103, 32'h80112233, 1, 1'b1, 4'h8, 32'h0,        1'b0, 32'hFFFFFF80};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0,        32'h103, 32'h80112233, 1, 1'b1, 4'h8, 32'h0,        1'b0, 32'h00000080};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'hDEADBEEF, 32'h202, 32'h0,        4, 1'b1, 4'hC, 32'hBEEF0000, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0,        32'h201, 32'h0,        1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0,        32'h200, 32'h0,        1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0,        32'h300, 32'h55555555, 0, 1'b1, 4'hF, 32'h0,        1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0,        32'h300, 32'h12345678, 4, 1'b1, 4'hF, 32'h0,        1'b0, 32'h12345678};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0,        32'h102, 32'h80017FFF, 2, 1'b1, 4'hC, 32'h0,        1'b0, 32'hFFFF8001};
    vecs[8]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0,        32'h100, 32'h1234ABCD, 1, 1'b1, 4'h3, 32'h0,        1'b0, 32'h0000ABCD};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h123456A5, 32'h101, 32'h0,        1, 1'b1, 4'h2, 32'h0000A500, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 32'h040, 32'h0,        3, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0,        32'h000, 32'h0,        1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFF,     32'h103, 32'h0,        1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0,        32'h000, 32'h0,        1, 1'b0, 4'h0, 32'h0,        1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0,        32'h000, 32'hAAAAAA7F, 1, 1'b1, 4'h1, 32'h0,        1'b0, 32'h0000007F};

    repeat (3) @(posedge clk);
    #1;
    chk("rst32_en", 64'(bus32.mem_en), 64'd0);
    chk("rst32_outs", {bus32.mem_wdata, bus32.mem_addr}, 64'd0);
    chk("rst32_misc", {59'd0, bus32.mem_wr, bus32.mem_be}, 64'd0);
    chk("rst32_done", {bus32.rd_data, 30'd0, bus32.done, bus32.err}, 64'd0);
    chk("rst32_ready", 64'(bus32.in_ready), 64'd1);
    chk("rst64_outs", bus64.mem_wdata | bus64.rd_data | 64'(bus64.mem_be) | 64'(bus64.mem_addr), 64'd0);
    chk("rst64_ctl", {61'd0, bus64.mem_en, bus64.done, bus64.err}, 64'd0);
    chk("rst64_ready", 64'(bus64.in_ready), 64'd1);
    rst32_n = 1'b1;
    rst64_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) run32($sformatf("v%0d", i), vecs[i]);

    for (int i = 0; i < 24; i++) begin
      v = mk_rand();
      run32($sformatf("r%0d", i), v);
    end

    // mem_ack while idle must not produce anything
    bus32.mem_ack = 1'b1;
    tick();
    bus32.mem_ack = 1'b0;
    chk("idle_ack_done", 64'(bus32.done), 64'd0);
    chk("idle_ack_en", 64'(bus32.mem_en), 64'd0);

    // back-to-back: second request accepted in the done cycle of the first
    bus32.in_valid = 1'b1; bus32.op_ld = 1'b1; bus32.op_st = 1'b0;
    bus32.size = 2'd2; bus32.sign_ext = 1'b0; bus32.in_b = 32'h10;
    exp_q.push_back({1'b0, 32'h0, 32'h11112222});
    tick();
    bus32.in_valid = 1'b0;
    chk("b2b_en1", 64'(bus32.mem_en), 64'd1);
    bus32.mem_ack = 1'b1; bus32.mem_rdata = 32'h11112222;
    tick();
    bus32.mem_ack = 1'b0;
    chk("b2b_done1", 64'(bus32.done), 64'd1);
    if (bus32.done) sb_pop("b2b_a", bus32.err, 64'(bus32.rd_data));
    else sb_drop();
    chk("b2b_ready", 64'(bus32.in_ready), 64'd1);
    bus32.in_valid = 1'b1; bus32.op_ld = 1'b0; bus32.op_st = 1'b1;
    bus32.size = 2'd0; bus32.in_a = 32'h77; bus32.in_b = 32'h21;
    exp_q.push_back({1'b0, 64'h0});
    tick();
    bus32.in_valid = 1'b0; bus32.op_st = 1'b0;
    chk("b2b_en2", 64'(bus32.mem_en), 64'd1);
    chk("b2b_addr2", 64'(bus32.mem_addr), 64'h21);
    chk("b2b_be2", 64'(bus32.mem_be), 64'h2);
    chk("b2b_wd2", 64'(bus32.mem_wdata), 64'h7700);
    chk("b2b_nodone", 64'(bus32.done), 64'd0);
    bus32.mem_ack = 1'b1;
    tick();
    bus32.mem_ack = 1'b0;
    chk("b2b_done2", 64'(bus32.done), 64'd1);
    if (bus32.done) sb_pop("b2b_b", bus32.err, 64'(bus32.rd_data));
    else sb_drop();
    tick();

    // 64-bit unit
    run64("d_dword", 1'b1, 1'b0, 2'd3, 1'b0, 64'h0, 32'h8, 64'h0123456789ABCDEF,
          8'hFF, 64'h0, 64'h0123456789ABCDEF);
    run64("d_byte7", 1'b1, 1'b0, 2'd0, 1'b1, 64'h0, 32'hF, 64'h9C00_0000_0000_0011,
          8'h80, 64'h0, 64'hFFFF_FFFF_FFFF_FF9C);
    run64("d_stw", 1'b0, 1'b1, 2'd2, 1'b0, 64'hAABBCCDD_11223344, 32'h4, 64'h0,
          8'hF0, 64'h11223344_00000000, 64'h0);
    run64("d_sthalf6", 1'b0, 1'b1, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_5AA5, 32'h16, 64'h0,
          8'hC0, 64'h5AA5_0000_0000_0000, 64'h0);

    // misaligned dword on the 64-bit unit
    bus64.in_valid = 1'b1; bus64.op_ld = 1'b1; bus64.op_st = 1'b0; bus64.size = 2'd3; bus64.in_b = 32'hC;
    exp_q.push_back({1'b1, 64'h0});
    tick();
    bus64.in_valid = 1'b0; bus64.op_ld = 1'b0;
    chk("d_mis_en", 64'(bus64.mem_en), 64'd0);
    chk("d_mis_done", 64'(bus64.done), 64'd1);
    if (bus64.done) sb_pop("d_mis", bus64.err, bus64.rd_data);
    else sb_drop();
    tick();

    // reset in the middle of a transaction drops it silently
    bus64.in_valid = 1'b1; bus64.op_ld = 1'b1; bus64.size = 2'd2; bus64.in_b = 32'h10;
    tick();
    bus64.in_valid = 1'b0; bus64.op_ld = 1'b0;
    chk("d_rst_en1", 64'(bus64.mem_en), 64'd1);
    tick();
    #2;
    rst64_n = 1'b0;
    #1;
    chk("d_rst_async_en", 64'(bus64.mem_en), 64'd0);
    chk("d_rst_state", 64'(dbg64), 64'd0);
    tick();
    rst64_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d_rst_nodone%0d", i), 64'(bus64.done), 64'd0);
      tick();
    end

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
